// File: rtl/alu_bist_ctrl.sv
// Built-in self-test controller for param_alu: LFSR vector generator, MISR compactor
// and golden-signature compare, with a LAT-deep valid pipe for pipelined ALUs.
module alu_bist_ctrl #(
  parameter int               WIDTH       = 32,
  parameter int               OPC_W       = 4,
  parameter int               NUM_OPS     = 9,
  parameter int               FLAG_W      = 4,
  parameter int               NUM_VECTORS = 1024,
  parameter int               LAT         = 0,
  parameter logic [WIDTH-1:0] TAPS        = 32'h8020_0003,
  parameter logic [WIDTH-1:0] SEED_A      = 32'h1234_5678,
  parameter logic [WIDTH-1:0] SEED_B      = 32'h9ABC_DEF1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic [WIDTH-1:0]                   golden_sig,
  output logic [WIDTH-1:0]                   operand_a,
  output logic [WIDTH-1:0]                   operand_b,
  output logic [OPC_W-1:0]                   opcode,
  output logic                               signed_op,
  output logic                               vec_valid,
  input  logic [WIDTH-1:0]                   alu_result,
  input  logic [FLAG_W-1:0]                  alu_flags,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [WIDTH-1:0]                   signature,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count
);

  localparam int CNT_W = $clog2(NUM_VECTORS + 1);
  localparam int DR_W  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   lfsr_a, lfsr_b, misr;
  logic [OPC_W-1:0]   op_cnt;
  logic               sgn;
  logic [CNT_W-1:0]   vec_cnt;
  logic [DR_W-1:0]    drain_cnt;
  logic               pass_q;
  logic               start_acc;
  logic               last_vec;
  logic               run;
  logic               cap_en;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0]  m,
                                                 input logic [WIDTH-1:0]  r,
                                                 input logic [FLAG_W-1:0] f);
    return lfsr_step(m) ^ r ^ WIDTH'(f);
  endfunction

  // abort outranks start, so a simultaneous pair never launches a run
  assign start_acc = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign last_vec  = (vec_cnt == CNT_W'(NUM_VECTORS - 1));
  assign run       = (state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) state_nx = S_RUN;
        S_RUN:          if (last_vec) state_nx = (LAT > 0) ? S_DRAIN : S_CHECK;
        S_DRAIN:        if (drain_cnt == DR_W'(LAT - 1)) state_nx = S_CHECK;
        S_CHECK:        state_nx = S_DONE;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vec_valid = run;
    operand_a = run ? lfsr_a : '0;
    operand_b = run ? lfsr_b : '0;
    opcode    = run ? op_cnt : '0;
    signed_op = run ? sgn : 1'b0;
    busy      = (state == S_RUN) || (state == S_DRAIN) || (state == S_CHECK);
    done      = (state == S_DONE);
    pass      = pass_q;
    signature = misr;
    vec_count = vec_cnt;
  end

  // Stage p0: vector generation, one operand pair per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
      op_cnt  <= '0;
      sgn     <= 1'b0;
      vec_cnt <= '0;
    end else if (start_acc) begin
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
      op_cnt  <= '0;
      sgn     <= 1'b0;
      vec_cnt <= '0;
    end else if (run) begin
      lfsr_a  <= lfsr_step(lfsr_a);
      lfsr_b  <= lfsr_step(lfsr_b);
      vec_cnt <= vec_cnt + 1'b1;
      if (op_cnt == OPC_W'(NUM_OPS - 1)) begin
        op_cnt <= '0;
        sgn    <= ~sgn;
      end else begin
        op_cnt <= op_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    drain_cnt <= '0;
    else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 1'b1;
    else                        drain_cnt <= '0;
  end

  // Stage p1..pLAT: valid delayed to line up with the ALU result
  generate
    if (LAT == 0) begin : g_comb_cap
      assign cap_en = vec_valid && !abort;
    end else begin : g_pipe_cap
      logic [LAT-1:0] vld_p;
      always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= vec_valid;
          for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
      end
      assign cap_en = vld_p[LAT-1] && !abort;
    end
  endgenerate

  // Capture stage: fold result and flags into the signature
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            misr <= '0;
    else if (start_acc) misr <= '0;
    else if (cap_en)    misr <= misr_step(misr, alu_result, alu_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pass_q <= 1'b0;
    else if (abort || start_acc) pass_q <= 1'b0;
    else if (state == S_CHECK)  pass_q <= (misr == golden_sig);
  end

endmodule
